plic_claim_ctrl: RTL

CPU-facing end of the PLIC interrupt path. Consumes the arbitrated `intr_ev`/`vecto_no` pair from the priority determiner and qualifies it against the global enable `I_flag`. It then runs the claim / end-of-interrupt (EOI) handshake with the core and clears the serviced source's pending bit. There is one interrupt in service at a time (no nesting), with a stability filter on the incoming vector and a claim timeout.

---
 rtl/plic_pkg.sv | 17 +
 rtl/plic_timeout_cnt.sv | 31 +++
 rtl/plic_claim_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/plic_pkg.sv
// Shared types and helpers for the PLIC claim/EOI controller.
package plic_pkg;
  localparam int NUM_IRQ_DEF = 8;
  localparam int VEC_W_DEF   = 4;
  localparam logic [VEC_W_DEF-1:0] VEC_NONE = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    ASSERT  = 2'd2,
    SERVICE = 2'd3
  } claim_state_t;

  function automatic logic [31:0] vec2onehot(input logic [7:0] vec);
    return 32'd1 << vec;
  endfunction
endpackage

// File: rtl/plic_timeout_cnt.sv
// Clearable saturating up-counter; clear has priority over increment.
module plic_timeout_cnt #(
  parameter int W = 8
) (
  input  logic         pclk,
  input  logic         preset_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/plic_claim_ctrl.sv
// CPU-facing PLIC end: qualifies the arbitrated vector, raises cpu_irq and
// runs the claim / EOI handshake with a single interrupt in service.
module plic_claim_ctrl
  import plic_pkg::*;
#(
  parameter int NUM_IRQ    = NUM_IRQ_DEF,
  parameter int VEC_W      = VEC_W_DEF,
  parameter int STABLE_CYC = 2,
  parameter int CLAIM_TO   = 64
) (
  input  logic               pclk,
  input  logic               preset_n,
  input  logic               intr_ev,
  input  logic [VEC_W-1:0]   vecto_no,
  input  logic               I_flag,
  output logic               cpu_irq,
  input  logic               claim_req,
  output logic               claim_vld,
  output logic [VEC_W-1:0]   claim_vec,
  input  logic               eoi_req,
  input  logic [VEC_W-1:0]   eoi_vec,
  output logic [NUM_IRQ-1:0] irq_clr,
  output logic [NUM_IRQ-1:0] in_service,
  output logic               eoi_err,
  output logic               claim_to_err,
  output logic [1:0]         dbg_state
);
  localparam int QW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(CLAIM_TO + 1);

  claim_state_t state_q, state_d;
  logic [VEC_W-1:0]   act_vec_q, act_vec_d;
  logic               cpu_irq_q, cpu_irq_d;
  logic               claim_vld_q, claim_vld_d;
  logic [VEC_W-1:0]   claim_vec_q, claim_vec_d;
  logic [NUM_IRQ-1:0] irq_clr_q, irq_clr_d;
  logic [NUM_IRQ-1:0] in_service_q, in_service_d;
  logic               eoi_err_q, eoi_err_d;
  logic               claim_to_err_q, claim_to_err_d;

  logic [QW-1:0]      qual_cnt;
  logic [TW-1:0]      to_cnt;
  logic               qual_done, to_done, vec_in_range;
  logic [NUM_IRQ-1:0] act_onehot;

  // Both counters run only while their owning state is active and clear otherwise.
  plic_timeout_cnt #(.W(QW)) u_qual_cnt (
    .pclk     (pclk),
    .preset_n (preset_n),
    .clr_i    (state_q != QUAL),
    .inc_i    (state_q == QUAL),
    .cnt_o    (qual_cnt)
  );

  plic_timeout_cnt #(.W(TW)) u_to_cnt (
    .pclk     (pclk),
    .preset_n (preset_n),
    .clr_i    (state_q != ASSERT),
    .inc_i    (state_q == ASSERT),
    .cnt_o    (to_cnt)
  );

  assign qual_done    = (qual_cnt == QW'(STABLE_CYC - 1));
  assign to_done      = (to_cnt == TW'(CLAIM_TO - 1));
  assign vec_in_range = (32'(vecto_no) < NUM_IRQ);
  assign act_onehot   = NUM_IRQ'(vec2onehot(8'(act_vec_q)));

  always_comb begin
    state_d        = state_q;
    act_vec_d      = act_vec_q;
    cpu_irq_d      = cpu_irq_q;
    claim_vld_d    = 1'b0;
    claim_vec_d    = claim_vec_q;
    irq_clr_d      = '0;
    in_service_d   = in_service_q;
    eoi_err_d      = 1'b0;
    claim_to_err_d = 1'b0;

    // Stray strobes answer "none"/error; the state cases below override them.
    if (claim_req) begin
      claim_vld_d = 1'b1;
      claim_vec_d = '1;
    end
    if (eoi_req) begin
      eoi_err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (intr_ev && I_flag && vec_in_range) begin
          act_vec_d = vecto_no;
          state_d   = QUAL;
        end
      end
      QUAL: begin
        if (!intr_ev || !I_flag || (vecto_no != act_vec_q)) begin
          state_d = IDLE;
        end else if (qual_done) begin
          cpu_irq_d = 1'b1;
          state_d   = ASSERT;
        end
      end
      ASSERT: begin
        if (claim_req) begin
          claim_vec_d  = act_vec_q;
          irq_clr_d    = act_onehot;
          in_service_d = act_onehot;
          cpu_irq_d    = 1'b0;
          state_d      = SERVICE;
        end else if (!I_flag) begin
          cpu_irq_d = 1'b0;
          state_d   = IDLE;
        end else if (to_done) begin
          claim_to_err_d = 1'b1;
          cpu_irq_d      = 1'b0;
          state_d        = IDLE;
        end
      end
      SERVICE: begin
        if (eoi_req && (eoi_vec == act_vec_q)) begin
          eoi_err_d    = 1'b0;
          in_service_d = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q        <= IDLE;
      act_vec_q      <= '0;
      cpu_irq_q      <= 1'b0;
      claim_vld_q    <= 1'b0;
      claim_vec_q    <= '0;
      irq_clr_q      <= '0;
      in_service_q   <= '0;
      eoi_err_q      <= 1'b0;
      claim_to_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      act_vec_q      <= act_vec_d;
      cpu_irq_q      <= cpu_irq_d;
      claim_vld_q    <= claim_vld_d;
      claim_vec_q    <= claim_vec_d;
      irq_clr_q      <= irq_clr_d;
      in_service_q   <= in_service_d;
      eoi_err_q      <= eoi_err_d;
      claim_to_err_q <= claim_to_err_d;
    end
  end

  assign cpu_irq      = cpu_irq_q;
  assign claim_vld    = claim_vld_q;
  assign claim_vec    = claim_vec_q;
  assign irq_clr      = irq_clr_q;
  assign in_service   = in_service_q;
  assign eoi_err      = eoi_err_q;
  assign claim_to_err = claim_to_err_q;
  assign dbg_state    = state_q;
endmodule
